// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// bubble insertion, flush and saturating performance counters.
module pipe_stage_reg #(
    parameter int                 DATA_W    = 96,
    parameter int                 CTRL_W    = 16,
    parameter logic [CTRL_W-1:0]  CTRL_NOP  = {CTRL_W{1'b0}},
    parameter bit                 ZERO_DATA = 1'b1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  hold_cnt
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    logic              out_valid_r, out_valid_s;
    logic [CTRL_W-1:0] out_ctrl_r,  out_ctrl_s;
    logic [DATA_W-1:0] out_data_r,  out_data_s;
    logic              sk_valid_r,  sk_valid_s;
    logic [CTRL_W-1:0] sk_ctrl_r,   sk_ctrl_s;
    logic [DATA_W-1:0] sk_data_r,   sk_data_s;
    logic [CNT_W-1:0]  bubble_cnt_r, flush_cnt_r, hold_cnt_r;
    logic              acc_s, ld_s;
    logic              bubble_inc_s, hold_inc_s;

    assign in_ready     = ~sk_valid_r & ~bubble & ~reset;
    assign acc_s        = in_valid & in_ready & ~flush;
    assign ld_s         = out_ready | ~out_valid_r;
    assign bubble_inc_s = ~flush & bubble & ld_s & ~sk_valid_r;
    assign hold_inc_s   = out_valid_r & ~out_ready;

    assign out_valid  = out_valid_r;
    assign out_ctrl   = out_ctrl_r;
    assign out_data   = out_data_r;
    assign bubble_cnt = bubble_cnt_r;
    assign flush_cnt  = flush_cnt_r;
    assign hold_cnt   = hold_cnt_r;

    // Next-state for output and skid slots: flush beats normal update.
    always_comb begin
        out_valid_s = out_valid_r;
        out_ctrl_s  = out_ctrl_r;
        out_data_s  = out_data_r;
        sk_valid_s  = sk_valid_r;
        sk_ctrl_s   = sk_ctrl_r;
        sk_data_s   = sk_data_r;
        if (flush) begin
            out_valid_s = 1'b0;
            out_ctrl_s  = CTRL_NOP;
            out_data_s  = ZERO_DATA ? DATA_ZERO : out_data_r;
            sk_valid_s  = 1'b0;
            sk_ctrl_s   = CTRL_NOP;
            sk_data_s   = ZERO_DATA ? DATA_ZERO : sk_data_r;
        end else if (ld_s) begin
            if (sk_valid_r) begin
                out_valid_s = 1'b1;
                out_ctrl_s  = sk_ctrl_r;
                out_data_s  = sk_data_r;
                sk_valid_s  = 1'b0;
            end else if (acc_s) begin
                out_valid_s = 1'b1;
                out_ctrl_s  = in_ctrl;
                out_data_s  = in_data;
            end else begin
                out_valid_s = 1'b0;
                out_ctrl_s  = CTRL_NOP;
                out_data_s  = ZERO_DATA ? DATA_ZERO : out_data_r;
            end
        end else if (acc_s) begin
            // Output is stalled: park the accepted word so nothing is dropped.
            sk_valid_s = 1'b1;
            sk_ctrl_s  = in_ctrl;
            sk_data_s  = in_data;
        end else begin
            sk_valid_s = sk_valid_r;
        end
    end

    // Slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_ctrl_r  <= CTRL_NOP;
            out_data_r  <= DATA_ZERO;
            sk_valid_r  <= 1'b0;
            sk_ctrl_r   <= CTRL_NOP;
            sk_data_r   <= DATA_ZERO;
        end else begin
            out_valid_r <= out_valid_s;
            out_ctrl_r  <= out_ctrl_s;
            out_data_r  <= out_data_s;
            sk_valid_r  <= sk_valid_s;
            sk_ctrl_r   <= sk_ctrl_s;
            sk_data_r   <= sk_data_s;
        end
    end

    // Performance counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
            hold_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            bubble_cnt_r <= bubble_inc_s ? sat_inc(bubble_cnt_r) : bubble_cnt_r;
            flush_cnt_r  <= flush        ? sat_inc(flush_cnt_r)  : flush_cnt_r;
            hold_cnt_r   <= hold_inc_s   ? sat_inc(hold_cnt_r)   : hold_cnt_r;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg: two instances (wide/zeroing and narrow/holding
// with 2-bit counters) checked against a FIFO-style model of stage occupancy.
module tb_pipe_stage_reg;

    localparam logic [15:0] NOP_A = 16'h5A3C;
    localparam logic [3:0]  NOP_B = 4'h0;
    localparam int          NCYC  = 3200;

    logic        clk = 1'b0;
    logic        reset, in_valid, bubble, flush, out_ready;
    logic [15:0] in_ctrl;
    logic [95:0] in_data;

    logic        in_ready_a, out_valid_a;
    logic [15:0] out_ctrl_a, bcnt_a, fcnt_a, hcnt_a;
    logic [95:0] out_data_a;

    logic        in_ready_b, out_valid_b;
    logic [3:0]  out_ctrl_b;
    logic [7:0]  out_data_b;
    logic [1:0]  bcnt_b, fcnt_b, hcnt_b;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg #(.DATA_W(96), .CTRL_W(16), .CTRL_NOP(NOP_A), .ZERO_DATA(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_ctrl(in_ctrl), .in_data(in_data), .bubble(bubble), .flush(flush),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
        .out_data(out_data_a), .bubble_cnt(bcnt_a), .flush_cnt(fcnt_a), .hold_cnt(hcnt_a)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(4), .CTRL_NOP(NOP_B), .ZERO_DATA(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_ctrl(in_ctrl[3:0]), .in_data(in_data[7:0]), .bubble(bubble), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
        .out_data(out_data_b), .bubble_cnt(bcnt_b), .flush_cnt(fcnt_b), .hold_cnt(hcnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Reference model: the stage is a FIFO of at most two instructions.
    logic [15:0] mq_ctrl[$];
    logic [95:0] mq_data[$];
    int          m_bcnt, m_fcnt, m_hcnt;
    logic [95:0] m_data;
    logic [7:0]  m_data2;

    initial begin
        int  sz, phase;
        bit  acc, pop, exp_rdy;
        m_bcnt = 0; m_fcnt = 0; m_hcnt = 0; m_data = '0; m_data2 = '0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            phase   = (cyc / 200) % 4;
            in_ctrl = 16'($urandom);
            in_data = {$urandom, $urandom, $urandom};
            case (phase)
                0: begin out_ready = 1'b1; bubble = 1'b0; flush = 1'b0;
                         in_valid = ($urandom_range(0, 9) != 0); reset = 1'b0; end
                1: begin out_ready = ($urandom_range(0, 9) < 6); bubble = ($urandom_range(0, 19) < 3);
                         flush = ($urandom_range(0, 19) == 0); in_valid = ($urandom_range(0, 9) < 7);
                         reset = ($urandom_range(0, 199) == 0); end
                2: begin out_ready = ($urandom_range(0, 9) == 0); bubble = ($urandom_range(0, 9) == 0);
                         flush = ($urandom_range(0, 29) == 0); in_valid = ($urandom_range(0, 9) < 8);
                         reset = 1'b0; end
                default: begin out_ready = $urandom_range(0, 1); bubble = $urandom_range(0, 1);
                         flush = ($urandom_range(0, 9) == 0); in_valid = $urandom_range(0, 1);
                         reset = ($urandom_range(0, 199) == 0); end
            endcase
            if (cyc < 2) reset = 1'b1;
            #1;
            sz      = mq_ctrl.size();
            exp_rdy = !reset && (sz < 2) && !bubble;
            check("in_ready_a", in_ready_a, exp_rdy);
            check("in_ready_b", in_ready_b, exp_rdy);
            if (cyc > 0) begin
                check("out_valid_a", out_valid_a, sz > 0);
                check("out_ctrl_a", out_ctrl_a, (sz > 0) ? mq_ctrl[0] : NOP_A);
                check("out_data_a", out_data_a, m_data);
                check("bubble_cnt_a", bcnt_a, sat(m_bcnt, 65535));
                check("flush_cnt_a", fcnt_a, sat(m_fcnt, 65535));
                check("hold_cnt_a", hcnt_a, sat(m_hcnt, 65535));
                check("out_valid_b", out_valid_b, sz > 0);
                check("out_ctrl_b", out_ctrl_b, (sz > 0) ? mq_ctrl[0][3:0] : NOP_B);
                check("out_data_b", out_data_b, m_data2);
                check("bubble_cnt_b", bcnt_b, sat(m_bcnt, 3));
                check("flush_cnt_b", fcnt_b, sat(m_fcnt, 3));
                check("hold_cnt_b", hcnt_b, sat(m_hcnt, 3));
            end
            // Advance the model to the state after the coming clock edge.
            if (reset) begin
                mq_ctrl.delete(); mq_data.delete();
                m_bcnt = 0; m_fcnt = 0; m_hcnt = 0; m_data = '0; m_data2 = '0;
            end else begin
                if (flush) m_fcnt++;
                if (sz > 0 && !out_ready) m_hcnt++;
                if (!flush && bubble && sz < 2 && (out_ready || sz == 0)) m_bcnt++;
                if (flush) begin
                    mq_ctrl.delete(); mq_data.delete();
                end else begin
                    acc = in_valid && (sz < 2) && !bubble;
                    pop = (sz > 0) && out_ready;
                    if (pop) begin void'(mq_ctrl.pop_front()); void'(mq_data.pop_front()); end
                    if (acc) begin mq_ctrl.push_back(in_ctrl); mq_data.push_back(in_data); end
                end
                if (mq_ctrl.size() > 0) begin
                    m_data  = mq_data[0];
                    m_data2 = mq_data[0][7:0];
                end else begin
                    m_data  = '0;
                end
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
